ball_physics: RTL

Ball motion, collision and scoring engine for the Pong playfield. It sits directly downstream of the paddle-position stage, consumes the 6-bit paddle top rows `p1y`/`p2y`, and advances a ball across a 64x64 grid at a fixed tick rate. It bounces the ball off the top/bottom walls and the paddles, detects misses, keeps both scores, and declares a winner. Outputs feed the display renderer and score display.

---
 rtl/ball_physics.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ball_physics.sv
// Pong ball engine: moves the ball on a 64x64 grid once per tick, bounces it off
// walls and paddles, keeps both scores and declares the winner.
module ball_physics #(
    parameter int unsigned TICK_DIV    = 1_000_000,
    parameter int unsigned PADDLE_H    = 8,
    parameter int unsigned SERVE_TICKS = 32,
    parameter int unsigned WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reset_game,
    input  logic [5:0] p1y,
    input  logic [5:0] p2y,
    output logic [5:0] ball_x,
    output logic [5:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       point_p1,
    output logic       point_p2,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SERVE_W = $clog2(SERVE_TICKS + 1);
    localparam logic [5:0]  CENTRE  = 6'd32;

    typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_OVER} state_e;

    state_e              state_q;
    logic [TICK_W-1:0]   tick_q;
    logic [SERVE_W-1:0]  serve_q;
    logic [5:0]          p1_meta_q, p1_sync_q, p2_meta_q, p2_sync_q;
    logic [5:0]          x_q, y_q, x_d, y_d;
    logic                dx_q, dy_q, dx_d, dy_d;
    logic [3:0]          score1_q, score2_q;
    logic                point_p1_q, point_p2_q, game_over_q, winner_q;

    logic                tick_c, hit1_c, hit2_c, score1_evt_c, score2_evt_c;
    logic [6:0]          p1_bot_c, p2_bot_c;

    assign tick_c = (tick_q == TICK_W'(TICK_DIV - 1));

    // Paddle span is evaluated 7-bit so a paddle near the bottom is clipped, not wrapped.
    assign p1_bot_c = {1'b0, p1_sync_q} + 7'(PADDLE_H - 1);
    assign p2_bot_c = {1'b0, p2_sync_q} + 7'(PADDLE_H - 1);
    assign hit1_c   = (y_q >= p1_sync_q) && ({1'b0, y_q} <= p1_bot_c);
    assign hit2_c   = (y_q >= p2_sync_q) && ({1'b0, y_q} <= p2_bot_c);

    // Next ball position; x and y are resolved independently from current values.
    always_comb begin
        y_d          = y_q;
        dy_d         = dy_q;
        x_d          = x_q;
        dx_d         = dx_q;
        score1_evt_c = 1'b0;
        score2_evt_c = 1'b0;

        if (!dy_q && (y_q == 6'd0)) begin
            dy_d = 1'b1;
            y_d  = 6'd1;
        end else if (dy_q && (y_q == 6'd63)) begin
            dy_d = 1'b0;
            y_d  = 6'd62;
        end else if (dy_q) begin
            y_d = y_q + 6'd1;
        end else begin
            y_d = y_q - 6'd1;
        end

        if (dx_q && (x_q == 6'd61) && hit2_c) begin
            dx_d = 1'b0;
            x_d  = 6'd60;
        end else if (!dx_q && (x_q == 6'd2) && hit1_c) begin
            dx_d = 1'b1;
            x_d  = 6'd3;
        end else if (dx_q && (x_q == 6'd63)) begin
            score1_evt_c = 1'b1;
        end else if (!dx_q && (x_q == 6'd0)) begin
            score2_evt_c = 1'b1;
        end else if (dx_q) begin
            x_d = x_q + 6'd1;
        end else begin
            x_d = x_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || reset_game) begin
            state_q     <= ST_SERVE;
            tick_q      <= '0;
            serve_q     <= '0;
            p1_meta_q   <= '0;
            p1_sync_q   <= '0;
            p2_meta_q   <= '0;
            p2_sync_q   <= '0;
            x_q         <= CENTRE;
            y_q         <= CENTRE;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            score1_q    <= '0;
            score2_q    <= '0;
            point_p1_q  <= 1'b0;
            point_p2_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            p1_meta_q  <= p1y;
            p1_sync_q  <= p1_meta_q;
            p2_meta_q  <= p2y;
            p2_sync_q  <= p2_meta_q;
            tick_q     <= tick_c ? '0 : tick_q + TICK_W'(1);
            point_p1_q <= 1'b0;
            point_p2_q <= 1'b0;

            if (tick_c) begin
                case (state_q)
                    ST_SERVE: begin
                        if (serve_q == SERVE_W'(SERVE_TICKS - 1)) begin
                            serve_q <= '0;
                            state_q <= ST_PLAY;
                        end else begin
                            serve_q <= serve_q + SERVE_W'(1);
                        end
                    end
                    ST_PLAY: begin
                        // A score recentres the ball and aims it at the player who lost.
                        if (score1_evt_c) begin
                            score1_q   <= score1_q + 4'd1;
                            point_p1_q <= 1'b1;
                            x_q        <= CENTRE;
                            y_q        <= CENTRE;
                            dx_q       <= 1'b1;
                            if ((score1_q + 4'd1) == 4'(WIN_SCORE)) begin
                                state_q     <= ST_OVER;
                                game_over_q <= 1'b1;
                                winner_q    <= 1'b0;
                            end else begin
                                state_q <= ST_SERVE;
                            end
                        end else if (score2_evt_c) begin
                            score2_q   <= score2_q + 4'd1;
                            point_p2_q <= 1'b1;
                            x_q        <= CENTRE;
                            y_q        <= CENTRE;
                            dx_q       <= 1'b0;
                            if ((score2_q + 4'd1) == 4'(WIN_SCORE)) begin
                                state_q     <= ST_OVER;
                                game_over_q <= 1'b1;
                                winner_q    <= 1'b1;
                            end else begin
                                state_q <= ST_SERVE;
                            end
                        end else begin
                            x_q  <= x_d;
                            y_q  <= y_d;
                            dx_q <= dx_d;
                            dy_q <= dy_d;
                        end
                    end
                    ST_OVER: begin
                        state_q <= ST_OVER;
                    end
                    default: begin
                        state_q <= ST_SERVE;
                    end
                endcase
            end
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign point_p1  = point_p1_q;
    assign point_p2  = point_p2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
